// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package wb_pkg;

    localparam int WB_XLEN = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic               live;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    // True when both addresses name the same architectural register other than x0.
    function automatic logic rd_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order load buffer: circular storage with head/tail/count, every entry visible
// for compares, and a per-entry live-bit clear used to squash stale loads.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [4:0]                 push_rd,
    input  logic [XLEN-1:0]            push_data,
    input  logic                       pop,
    input  logic [DEPTH-1:0]           clr_live,
    output logic [CW-1:0]              count,
    output logic [PW-1:0]              head,
    output logic [DEPTH-1:0]           ent_live,
    output logic [DEPTH-1:0][4:0]      ent_rd,
    output logic [DEPTH-1:0][XLEN-1:0] ent_data
);

    logic [PW-1:0]              head_q, head_d;
    logic [PW-1:0]              tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic [DEPTH-1:0]           live_q, live_d;
    logic [DEPTH-1:0][4:0]      rd_q, rd_d;
    logic [DEPTH-1:0][XLEN-1:0] data_q, data_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Next-state: squash clears first, then pop retires the head, then push fills the tail.
    always_comb begin
        live_d  = live_q & ~clr_live;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            live_d[head_q] = 1'b0;
            head_d         = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        if (push) begin
            live_d[tail_q] = 1'b1;
            rd_d[tail_q]   = push_rd;
            data_d[tail_q] = push_data;
            tail_d         = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            live_q  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= REG_ZERO;
                data_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            live_q  <= live_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    assign count    = count_q;
    assign head     = head_q;
    assign ent_live = live_q;
    assign ent_rd   = rd_q;
    assign ent_data = data_q;

endmodule

// File: rtl/wb_port_scheduler.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Optional combinational bypass lookup is built when WB_BYPASS_EN is defined.
module wb_port_scheduler
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [4:0]                   alu_rd,
    input  logic [XLEN-1:0]              alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [4:0]                   ld_rd,
    input  logic [XLEN-1:0]              ld_data,
    output logic                         rf_we,
    output logic [4:0]                   rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    output logic [$clog2(DEPTH+1)-1:0]   wb_pending,
    input  logic [4:0]                   byp_rs1,
    input  logic [4:0]                   byp_rs2,
    output logic                         byp_hit1,
    output logic                         byp_hit2,
    output logic [XLEN-1:0]              byp_data1,
    output logic [XLEN-1:0]              byp_data2
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]              count;
    logic [PW-1:0]              head;
    logic [DEPTH-1:0]           ent_live;
    logic [DEPTH-1:0][4:0]      ent_rd;
    logic [DEPTH-1:0][XLEN-1:0] ent_data;
    logic [DEPTH-1:0]           clr_live;

    logic alu_live, ld_live, ld_squash, any_live, head_live;
    logic fifo_push, fifo_pop, direct_ld;

    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    wb_fifo #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_rd   (ld_rd),
        .push_data (ld_data),
        .pop       (fifo_pop),
        .clr_live  (clr_live),
        .count     (count),
        .head      (head),
        .ent_live  (ent_live),
        .ent_rd    (ent_rd),
        .ent_data  (ent_data)
    );

    assign ld_ready  = (count != CW'(DEPTH));
    assign alu_live  = alu_valid && (alu_rd != REG_ZERO);
    assign ld_live   = ld_valid && ld_ready && (ld_rd != REG_ZERO);
    assign ld_squash = alu_live && rd_match(ld_rd, alu_rd);
    assign any_live  = |ent_live;
    assign head_live = ent_live[head];

    // Dead heads retire for free; a live head only leaves when it gets the port.
    assign fifo_pop  = (count != {CW{1'b0}}) && (!head_live || !alu_live);
    assign direct_ld = ld_live && !alu_live && !any_live;
    assign fifo_push = ld_live && !direct_ld && !ld_squash;

    // Squash: a younger ALU write kills every buffered load to the same register.
    always_comb begin
        clr_live = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            clr_live[i] = alu_live && ent_live[i] && rd_match(ent_rd[i], alu_rd);
        end
    end

    // Port selection: ALU, then live buffer head, then a direct load.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (alu_live) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = alu_rd;
            rf_wdata_d = alu_data;
        end else if (head_live) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ent_rd[head];
            rf_wdata_d = ent_data[head];
        end else if (direct_ld) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_rd;
            rf_wdata_d = ld_data;
        end else begin
            rf_we_d    = 1'b0;
        end
    end

    // Registered write stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= REG_ZERO;
            rf_wdata_q <= {XLEN{1'b0}};
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign wb_pending = count;

`ifdef WB_BYPASS_EN
    logic [1:0][4:0]      byp_rs;
    logic [1:0]           byp_hit;
    logic [1:0][XLEN-1:0] byp_data;
    logic [PW-1:0]        byp_idx;

    assign byp_rs = {byp_rs2, byp_rs1};

    // Walk oldest to youngest so later matches win; the write stage is youngest of all.
    always_comb begin
        byp_hit  = 2'b00;
        byp_data = {2*XLEN{1'b0}};
        byp_idx  = {PW{1'b0}};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                byp_idx = PW'((int'(head) + i) % DEPTH);
                if (ent_live[byp_idx] && rd_match(ent_rd[byp_idx], byp_rs[k])) begin
                    byp_hit[k]  = 1'b1;
                    byp_data[k] = ent_data[byp_idx];
                end else begin
                    byp_hit[k]  = byp_hit[k];
                end
            end
            if (rf_we_q && rd_match(rf_waddr_q, byp_rs[k])) begin
                byp_hit[k]  = 1'b1;
                byp_data[k] = rf_wdata_q;
            end else begin
                byp_hit[k]  = byp_hit[k];
            end
        end
    end

    assign byp_hit1  = byp_hit[0];
    assign byp_hit2  = byp_hit[1];
    assign byp_data1 = byp_data[0];
    assign byp_data2 = byp_data[1];
`else
    logic unused_byp;
    assign unused_byp = ^{byp_rs1, byp_rs2, ent_data};
    assign byp_hit1   = 1'b0;
    assign byp_hit2   = 1'b0;
    assign byp_data1  = {XLEN{1'b0}};
    assign byp_data2  = {XLEN{1'b0}};
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Scoreboard bench for wb_port_scheduler: queue-level reference model plus a write monitor.
module tb_wb_port_scheduler;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alu_valid = 1'b0;
    logic [4:0]      alu_rd = 5'd0;
    logic [XLEN-1:0] alu_data = 32'd0;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic [4:0]      ld_rd = 5'd0;
    logic [XLEN-1:0] ld_data = 32'd0;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [CW-1:0]   wb_pending;
    logic [4:0]      byp_rs1 = 5'd0;
    logic [4:0]      byp_rs2 = 5'd0;
    logic            byp_hit1, byp_hit2;
    logic [XLEN-1:0] byp_data1, byp_data2;

    wb_port_scheduler #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .wb_pending (wb_pending),
        .byp_rs1    (byp_rs1),
        .byp_rs2    (byp_rs2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] rd; logic [31:0] data; bit live; } ment_t;
    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wr_t;

    ment_t mq[$];     // model load buffer, index 0 is oldest
    wr_t   exp_q[$];  // expected register-file writes
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit         m_we = 1'b0;
    logic [4:0] m_addr = 5'd0;
    logic [31:0] m_data = 32'd0;
    wr_t   mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Write monitor: every DUT write must match the oldest expected write, on time.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got rd=%0d data=0x%0h, required no write (cycle %0d)",
                             rf_waddr, rf_wdata, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("wr_addr", 64'(rf_waddr), 64'(mon_e.rd));
                    chk("wr_data", 64'(rf_wdata), 64'(mon_e.data));
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_write: got no write, required rd=%0d data=0x%0h (cycle %0d)",
                         mon_e.rd, mon_e.data, cyc);
            end
        end
    end

    task automatic byp_model(input logic [4:0] rs, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (rs != 5'd0) begin
            foreach (mq[i]) begin
                if (mq[i].live && mq[i].rd == rs) begin
                    h = 1'b1;
                    d = mq[i].data;
                end
            end
            if (m_we && m_addr == rs) begin
                h = 1'b1;
                d = m_data;
            end
        end
    endtask

    // One cycle: check status, drive inputs, check bypass, advance the reference model.
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        bit alu_live, rdy, ld_live, any_live, head_pop, head_wr, direct, wrote;
        logic [4:0]  w_rd;
        logic [31:0] w_data;
        logic        eh1, eh2;
        logic [31:0] ed1, ed2;
        @(negedge clk);
        chk("ld_ready", 64'(ld_ready), 64'(mq.size() != DEPTH));
        chk("wb_pending", 64'(wb_pending), 64'(mq.size()));
        alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_valid = lv;  ld_rd = lrd;  ld_data = ldat;
        byp_rs1 = rs1;  byp_rs2 = rs2;
        #1;
`ifdef WB_BYPASS_EN
        byp_model(rs1, eh1, ed1);
        byp_model(rs2, eh2, ed2);
`else
        eh1 = 1'b0; eh2 = 1'b0; ed1 = 32'd0; ed2 = 32'd0;
`endif
        chk("byp_hit1", 64'(byp_hit1), 64'(eh1));
        chk("byp_data1", 64'(byp_data1), 64'(ed1));
        chk("byp_hit2", 64'(byp_hit2), 64'(eh2));
        chk("byp_data2", 64'(byp_data2), 64'(ed2));

        alu_live = av && (ard != 5'd0);
        rdy      = (mq.size() != DEPTH);
        ld_live  = lv && rdy && (lrd != 5'd0);
        any_live = 1'b0;
        foreach (mq[i]) if (mq[i].live) any_live = 1'b1;
        head_pop = 1'b0;
        head_wr  = 1'b0;
        if (mq.size() > 0) begin
            if (!mq[0].live) head_pop = 1'b1;
            else if (!alu_live) begin head_pop = 1'b1; head_wr = 1'b1; end
        end
        direct = ld_live && !alu_live && !any_live;
        wrote = 1'b1;
        w_rd = 5'd0;
        w_data = 32'd0;
        if (alu_live) begin w_rd = ard; w_data = adat; end
        else if (head_wr) begin w_rd = mq[0].rd; w_data = mq[0].data; end
        else if (direct) begin w_rd = lrd; w_data = ldat; end
        else wrote = 1'b0;
        if (head_pop) void'(mq.pop_front());
        if (alu_live) foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
        if (ld_live && !direct && !(alu_live && lrd == ard)) mq.push_back(ment_t'{lrd, ldat, 1'b1});
        m_we = wrote;
        if (wrote) begin
            m_addr = w_rd;
            m_data = w_data;
            exp_q.push_back(wr_t'{cyc + 1, w_rd, w_data});
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    initial begin
        int nxt;
        bit acc;
        #12;
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_wb_pending", 64'(wb_pending), 64'd0);
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("rst_byp_hit1", 64'(byp_hit1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU alone
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle();
        // ALU and load collide: load writes one cycle later
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd4, 5'd3);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd3);
        idle();
        // ALU hogs the port while three loads are offered back to back
        nxt = 8;
        for (int c = 0; c < 10; c++) begin
            acc = (mq.size() != DEPTH) && (nxt <= 10);
            step(c < 4, 5'd1, 32'h100 + 32'(c), nxt <= 10, 5'(nxt), 32'h800 + 32'(nxt),
                 5'(nxt), 5'd8);
            if (acc) nxt++;
        end
        // Squash a buffered load
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd7, 32'hAA, 5'd7, 5'd2);
        step(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        idle();
        idle();
        // x0 ALU request with a direct load
        step(1'b1, 5'd0, 32'h123, 1'b1, 5'd9, 32'h55, 5'd0, 5'd9);
        idle();

        // Randomized traffic over a small register range to force collisions
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int c = 0; c < 20 && mq.size() != 0; c++) idle();

        // Reset with two live entries buffered
        step(1'b1, 5'd1, 32'h1, 1'b1, 5'd12, 32'hC12, 5'd0, 5'd0);
        step(1'b1, 5'd1, 32'h2, 1'b1, 5'd13, 32'hC13, 5'd0, 5'd0);
        @(negedge clk);
        chk("pre_reset_pending", 64'(wb_pending), 64'(mq.size()));
        alu_valid = 1'b0;
        ld_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rf_we", 64'(rf_we), 64'd0);
        chk("midrst_wb_pending", 64'(wb_pending), 64'd0);
        chk("midrst_ld_ready", 64'(ld_ready), 64'd1);
        mq.delete();
        exp_q.delete();
        m_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) idle();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
